// File: rtl/memio.sv
// memio: CPU memory/IO map with RAM, keyboard FIFO, ms timer with latch and LED register.
module memio #(
    parameter int RAM_ABITS  = 16,
    parameter int CLK_PER_MS = 25000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] I_ADDR,
    input  logic [7:0]  I_DATA,
    input  logic        I_WREN,
    output logic [7:0]  O_DATA,
    input  logic [7:0]  KB_DATA,
    input  logic        KB_STB,
    output logic [7:0]  O_LED
);
    localparam int FW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = FW + 1;
    localparam int PW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;

    logic [7:0]    ram [2**RAM_ABITS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   ms_q, ms_d, lat_q, lat_d;
    logic [7:0]    led_q, led_d;
    logic          wr, ram_sel, empty, full, pop, push, tick;

    // RESET gates the non-reset storage so nothing lands in RAM or the FIFO during reset
    assign wr      = I_WREN && !RESET;
    assign ram_sel = I_ADDR < 16'hFF00;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(FIFO_DEPTH);
    assign pop     = wr && I_ADDR == 16'hFF00 && !empty;
    assign push    = KB_STB && !RESET && (!full || pop);
    assign tick    = pre_q == PW'(CLK_PER_MS - 1);
    assign O_LED   = led_q;

    always_comb begin
        rd_d  = rd_q + FW'(pop);
        wr_d  = wr_q + FW'(push);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        ovf_d = (ovf_q && !(wr && I_ADDR == 16'hFF01 && I_DATA[2])) || (KB_STB && full && !pop);
        pre_d = tick ? '0 : pre_q + 1'b1;
        ms_d  = ms_q + 16'(tick);
        lat_d = (wr && I_ADDR == 16'hFF02) ? ms_q : lat_q;
        led_d = (wr && I_ADDR == 16'hFF04) ? I_DATA : led_q;
    end

    always_comb begin
        O_DATA = ram_sel                ? ram[I_ADDR[RAM_ABITS-1:0]] :
                 I_ADDR == 16'hFF00     ? (empty ? 8'h00 : fifo[rd_q]) :
                 I_ADDR == 16'hFF01     ? {5'b0, ovf_q, full, !empty} :
                 I_ADDR == 16'hFF02     ? lat_q[7:0] :
                 I_ADDR == 16'hFF03     ? lat_q[15:8] :
                 I_ADDR == 16'hFF04     ? led_q : 8'hFF;
    end

    always_ff @(posedge CLOCK) begin
        if (wr && ram_sel) ram[I_ADDR[RAM_ABITS-1:0]] <= I_DATA;
        if (push) fifo[wr_q] <= KB_DATA;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            pre_q <= '0;
            ms_q  <= '0;
            lat_q <= '0;
            led_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            pre_q <= pre_d;
            ms_q  <= ms_d;
            lat_q <= lat_d;
            led_q <= led_d;
        end
    end
endmodule

// File: tb/tb_memio.sv
// tb_memio: directed and randomized checks of memio against a queue/array reference model.
module tb_memio;
    logic        clk = 1'b0;
    logic        rst, wren, stb, rst1, wren1;
    logic [15:0] addr, addr1;
    logic [7:0]  wdata, kb, rdata, led, rdata1, led1;
    int          n_cmp = 0, n_bad = 0;

    byte unsigned m_ram [65536];
    logic [7:0]   m_q [$];
    bit           m_ovf;
    logic [15:0]  m_lat;
    logic [7:0]   m_led;
    int unsigned  m_cyc;

    always #5 clk = ~clk;

    memio #(.RAM_ABITS(16), .CLK_PER_MS(4), .FIFO_DEPTH(16)) dut (
        .CLOCK(clk), .RESET(rst), .I_ADDR(addr), .I_DATA(wdata), .I_WREN(wren),
        .O_DATA(rdata), .KB_DATA(kb), .KB_STB(stb), .O_LED(led));

    memio #(.RAM_ABITS(16), .CLK_PER_MS(1), .FIFO_DEPTH(16)) dut1 (
        .CLOCK(clk), .RESET(rst1), .I_ADDR(addr1), .I_DATA(8'h00), .I_WREN(wren1),
        .O_DATA(rdata1), .KB_DATA(8'h00), .KB_STB(1'b0), .O_LED(led1));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [15:0] a);
        if (a < 16'hFF00) return m_ram[a];
        case (a)
            16'hFF00: return m_q.size() != 0 ? m_q[0] : 8'h00;
            16'hFF01: return {5'b0, m_ovf, m_q.size() == 16, m_q.size() != 0};
            16'hFF02: return m_lat[7:0];
            16'hFF03: return m_lat[15:8];
            16'hFF04: return m_led;
            default:  return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0;
        m_lat = '0;
        m_led = '0;
        m_cyc = 0;
    endtask

    task automatic model_edge();
        bit p_pop, p_push, p_full;
        if (rst) return;
        p_full = m_q.size() == 16;
        p_pop  = wren && addr == 16'hFF00 && m_q.size() != 0;
        p_push = stb && (!p_full || p_pop);
        if (wren && addr < 16'hFF00) m_ram[addr] = wdata;
        if (wren && addr == 16'hFF02) m_lat = 16'(m_cyc / 4);
        if (wren && addr == 16'hFF04) m_led = wdata;
        if (wren && addr == 16'hFF01 && wdata[2]) m_ovf = 0;
        if (stb && p_full && !p_pop) m_ovf = 1;
        if (p_pop) void'(m_q.pop_front());
        if (p_push) m_q.push_back(kb);
        m_cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; wdata = d; wren = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        kb = b; stb = 1'b1;
        tick();
        stb = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1; wren = 1'b0; wren1 = 1'b0; stb = 1'b0;
        addr = '0; addr1 = '0; wdata = '0; kb = '0;
        model_reset();
        #2;
        tick(); tick();
        rd("rst_status", 16'hFF01, 8'h00);
        rd("rst_head", 16'hFF00, 8'h00);
        rd("rst_led_rd", 16'hFF04, 8'h00);
        rd("rst_latch", 16'hFF02, 8'h00);
        rd("rst_unmapped", 16'hFF07, 8'hFF);
        check("rst_led", led, 8'h00);
        rst = 1'b0;

        wr(16'h1234, 8'h5A);
        rd("ram_1234", 16'h1234, 8'h5A);
        wr(16'h1235, 8'hA5);
        rd("ram_1235", 16'h1235, 8'hA5);
        rd("ram_1234_b", 16'h1234, 8'h5A);
        wr(16'hFF10, 8'h77);
        rd("unmapped_ff10", 16'hFF10, 8'hFF);
        rd("ram_1234_c", 16'h1234, 8'h5A);
        wr(16'hFEFF, 8'h3C);
        rd("ram_feff", 16'hFEFF, 8'h3C);
        rd("unmapped_ffff", 16'hFFFF, 8'hFF);

        push(8'h11); push(8'h22); push(8'h33);
        rd("q3_status", 16'hFF01, 8'h01);
        rd("q3_head", 16'hFF00, 8'h11);
        rd("q3_head_again", 16'hFF00, 8'h11);
        wr(16'hFF00, 8'h00); wr(16'hFF00, 8'hAB);
        rd("q3_head_pop2", 16'hFF00, 8'h33);
        wr(16'hFF00, 8'h00);
        rd("q3_empty_status", 16'hFF01, 8'h00);
        rd("q3_empty_head", 16'hFF00, 8'h00);
        wr(16'hFF00, 8'h00);
        rd("pop_empty_status", 16'hFF01, 8'h00);

        for (int i = 0; i < 17; i++) push(8'(i));
        rd("ovf_status", 16'hFF01, 8'h07);
        rd("ovf_head", 16'hFF00, 8'h00);
        kb = 8'h55; stb = 1'b1; addr = 16'hFF00; wdata = 8'h00; wren = 1'b1;
        tick();
        stb = 1'b0; wren = 1'b0;
        rd("full_pp_status", 16'hFF01, 8'h07);
        rd("full_pp_head", 16'hFF00, 8'h01);
        wr(16'hFF01, 8'h04);
        rd("ovf_clr_status", 16'hFF01, 8'h03);
        wr(16'hFF01, 8'hFB);
        kb = 8'h66; stb = 1'b1; addr = 16'hFF01; wdata = 8'h04; wren = 1'b1;
        tick();
        stb = 1'b0; wren = 1'b0;
        rd("clr_vs_ovf", 16'hFF01, 8'h07);
        for (int i = 0; i < 16; i++) begin
            rd("drain_head", 16'hFF00, m_rd(16'hFF00));
            wr(16'hFF00, 8'h00);
        end
        rd("drained_status", 16'hFF01, 8'h04);
        wr(16'hFF01, 8'h04);
        kb = 8'h99; stb = 1'b1; addr = 16'hFF00; wren = 1'b1;
        tick();
        stb = 1'b0; wren = 1'b0;
        rd("empty_pp_status", 16'hFF01, 8'h01);
        rd("empty_pp_head", 16'hFF00, 8'h99);

        rst = 1'b1;
        model_reset();
        addr = 16'h1234; wdata = 8'hEE; wren = 1'b1; kb = 8'h42; stb = 1'b1;
        tick();
        wren = 1'b0; stb = 1'b0;
        rd("rst_no_ram_wr", 16'h1234, 8'h5A);
        rd("rst_no_push", 16'hFF01, 8'h00);
        rst = 1'b0;
        repeat (40) tick();
        wr(16'hFF02, 8'h00);
        rd("latch_lo", 16'hFF02, 8'h0A);
        rd("latch_hi", 16'hFF03, 8'h00);

        wr(16'hFF04, 8'hC3);
        check("led_c3", led, 8'hC3);
        rd("led_rd", 16'hFF04, 8'hC3);
        push(8'hD1); push(8'hD2);
        rd("pre_rst_status", 16'hFF01, 8'h01);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_led", led, 8'h00);
        rd("async_status", 16'hFF01, 8'h00);
        rd("async_head", 16'hFF00, 8'h00);
        rd("async_ram", 16'h1234, 8'h5A);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i), 8'($urandom));
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
            addr  = $urandom_range(0, 9) < 4 ? 16'h0100 + 16'($urandom_range(0, 15))
                                             : 16'hFF00 + 16'($urandom_range(0, 7) % 6);
            wdata = 8'($urandom);
            wren  = $urandom_range(0, 9) < 5;
            kb    = 8'($urandom);
            stb   = $urandom_range(0, 9) < 4;
            #1;
            check("rand_rd", rdata, m_rd(addr));
            check("rand_led", led, m_led);
            tick();
        end
        wren = 1'b0; stb = 1'b0;

        rst1 = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        addr1 = 16'hFF02; wren1 = 1'b1;
        @(posedge clk);
        #1;
        wren1 = 1'b0;
        #1;
        check("wrap_pre_lo", rdata1, 8'hFF);
        addr1 = 16'hFF03;
        #1;
        check("wrap_pre_hi", rdata1, 8'hFF);
        addr1 = 16'hFF02; wren1 = 1'b1;
        @(posedge clk);
        #1;
        wren1 = 1'b0;
        #1;
        check("wrap_lo", rdata1, 8'h00);
        addr1 = 16'hFF03;
        #1;
        check("wrap_hi", rdata1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
